// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between an instruction
// read requester and a data read/write requester, with a per-transaction wait timeout.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic              busy,
    output logic              timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_nx;
    logic grant, last_grant; // 1 = data side
    logic [7:0] wait_cnt;
    logic pick_d, start, done, expire;

    // expire fires on the BUSY cycle whose count would reach MAX_WAIT; mem_valid wins a tie
    always_comb begin
        pick_d   = d_req && (!i_req || !last_grant);
        start    = state == IDLE && (i_req || d_req);
        done     = state == BUSY && mem_valid;
        expire   = state == BUSY && !mem_valid && wait_cnt == 8'(MAX_WAIT - 1);
        state_nx = start ? BUSY : (done || expire) ? RESP : state == RESP ? IDLE : state;
        mem_req  = state == BUSY;
        busy     = state != IDLE;
        i_valid  = state == RESP && !grant;
        d_valid  = state == RESP && grant;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (start) begin
                grant      <= pick_d;
                last_grant <= pick_d;
                wait_cnt   <= '0;
                mem_we     <= pick_d && d_we;
                mem_addr   <= pick_d ? d_addr : i_addr;
                mem_wdata  <= pick_d ? d_wdata : '0;
            end
            if (state == BUSY && !mem_valid)
                wait_cnt <= wait_cnt + 8'd1;
            if ((done || expire) && !mem_we) begin
                if (grant)
                    d_rdata <= done ? mem_rdata : '0;
                else
                    i_rdata <= done ? mem_rdata : '0;
            end
            if (expire)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter; each request pushes its
// expected memory access and completion, which is popped when the memory port is served.
module tb_mem_arbiter;
    localparam int MW = 4;

    typedef struct {
        bit          side;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] resp;
        logic [31:0] rdata;
        bit          to;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, d_req, d_we, mem_valid;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_valid, d_valid, mem_req, mem_we, busy, timeout_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(bit side, logic [31:0] addr, bit we, logic [31:0] wdata,
                                 int lat, logic [31:0] resp, logic [31:0] rdata, bit to);
        sb.push_back('{side, addr, we, wdata, lat, resp, rdata, to});
    endfunction

    // Plays the memory for one transaction (lat < 0 means never answer) and checks completion.
    task automatic serve();
        exp_t e;
        int   n;
        chk("sb_nonempty", sb.size() > 0, 1);
        e = sb.pop_front();
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("grant_wait", n < 20, 1);
        chk("busy", busy, 1);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        chk("mem_wdata", mem_wdata, e.wdata);
        if (e.lat >= 0) begin
            repeat (e.lat) @(negedge clock);
            mem_valid = 1'b1;
            mem_rdata = e.resp;
        end
        n = 0;
        do begin
            @(negedge clock);
            mem_valid = 1'b0;
            n++;
        end while (!(i_valid || d_valid) && n < 20);
        chk("resp_latency", n, e.lat < 0 ? MW : 1);
        chk("i_valid", i_valid, !e.side);
        chk("d_valid", d_valid, e.side);
        chk(e.side ? "d_rdata" : "i_rdata", e.side ? d_rdata : i_rdata, e.rdata);
        chk("timeout_err", timeout_err, e.to);
        chk("mem_req_in_resp", mem_req, 0);
        @(negedge clock);
        chk("single_pulse", {i_valid, d_valid}, 2'b00);
    endtask

    initial begin
        {i_req, d_req, d_we, mem_valid} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        @(negedge clock);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {i_valid, d_valid}, 2'b00);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        reset = 1'b0;
        // simultaneous requests from reset release: I, then D, then I again
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF;
        push(0, 32'h10, 0, 32'h0, 1, 32'h1111_1111, 32'h1111_1111, 0);
        push(1, 32'h20, 0, 32'hFFFF_FFFF, 1, 32'h2222_2222, 32'h2222_2222, 0);
        push(0, 32'h10, 0, 32'h0, 1, 32'h3333_3333, 32'h3333_3333, 0);
        repeat (3) serve();
        i_req = 1'b0; d_req = 1'b0;
        // instruction read with two-cycle memory latency
        i_req = 1'b1; i_addr = 32'h100;
        push(0, 32'h100, 0, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        @(negedge clock);
        chk("arb_latency", mem_req, 1);
        serve();
        i_req = 1'b0;
        // data read, then a data write that must not disturb d_rdata
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
        push(1, 32'h300, 0, 32'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        serve();
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        push(1, 32'h200, 1, 32'h1234_5678, 0, 32'h0BAD_F00D, 32'hCAFE_F00D, 0);
        serve();
        d_req = 1'b0; d_we = 1'b0;
        // answer on the last allowed BUSY cycle: normal completion
        i_req = 1'b1; i_addr = 32'h400;
        push(0, 32'h400, 0, 32'h0, MW - 1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
        serve();
        // no answer: timeout with zero data, flag sticks
        i_addr = 32'h500;
        push(0, 32'h500, 0, 32'h0, -1, 32'h0, 32'h0, 1);
        serve();
        i_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("timeout_sticky", timeout_err, 1);
        // stray mem_valid while idle
        mem_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clock);
        mem_valid = 1'b0;
        chk("idle_mv_busy", busy, 0);
        chk("idle_mv_valids", {i_valid, d_valid}, 2'b00);
        chk("idle_mv_rdata", i_rdata, 0);
        @(negedge clock);
        chk("idle_mv_valids2", {i_valid, d_valid}, 2'b00);
        // asynchronous reset in the middle of a transaction
        i_req = 1'b1; i_addr = 32'h600;
        @(negedge clock);
        chk("mid_mem_req", mem_req, 1);
        chk("mid_mem_addr", mem_addr, 32'h600);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_busy", busy, 0);
        chk("async_mem_addr", mem_addr, 0);
        chk("async_d_rdata", d_rdata, 0);
        chk("async_timeout", timeout_err, 0);
        chk("async_valids", {i_valid, d_valid}, 2'b00);
        @(negedge clock);
        i_req = 1'b0; reset = 1'b0;
        mem_valid = 1'b1; mem_rdata = 32'h77;
        @(negedge clock);
        mem_valid = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valids", {i_valid, d_valid}, 2'b00);
        chk("post_rst_rdata", i_rdata, 0);
        repeat (2) begin
            @(negedge clock);
            chk("post_rst_quiet", {i_valid, d_valid, busy}, 3'b000);
        end
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter MAX_WAIT, default 255, memory-wait cycles before timeout (range 1..255).
REQ-004 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: i_req  input  1  instruction-side read request, level.
REQ-007 Port: i_addr  input  ADDR_W  instruction-side address.
REQ-008 Port: i_rdata  output  DATA_W  instruction-side read data, registered.
REQ-009 Port: i_valid  output  1  instruction-side completion pulse.
REQ-010 Port: d_req  input  1  data-side request, level.
REQ-011 Port: d_we  input  1  data-side write enable (1=write, 0=read).
REQ-012 Port: d_addr  input  ADDR_W  data-side address.
REQ-013 Port: d_wdata  input  DATA_W  data-side write data.
REQ-014 Port: d_rdata  output  DATA_W  data-side read data, registered.
REQ-015 Port: d_valid  output  1  data-side completion pulse.
REQ-016 Port: mem_req  output  1  memory request, held high for whole transaction.
REQ-017 Port: mem_we  output  1  memory write enable.
REQ-018 Port: mem_addr  output  ADDR_W  memory address, registered.
REQ-019 Port: mem_wdata  output  DATA_W  memory write data, registered.
REQ-020 Port: mem_rdata  input  DATA_W  memory read data, valid with mem_valid.
REQ-021 Port: mem_valid  input  1  memory completion pulse, one cycle.
REQ-022 Port: busy  output  1  high in any state other than IDLE.
REQ-023 Port: timeout_err  output  1  sticky timeout flag.

Function
REQ-024 FSM states SHALL be IDLE, BUSY, RESP; one outstanding transaction at a time.
REQ-025 Requesters SHALL hold req, addr, we, wdata stable until their x_valid pulse; the arbiter samples requests only in IDLE.
REQ-026 IDLE, only one req high: grant it, latch its addr/we/wdata into mem_* registers, go to BUSY; mem_req high the next cycle (1-cycle arbitration latency).
REQ-027 IDLE, both req high: grant the side not granted last (round-robin via last_grant register, reset value = D, so I wins the first tie).
REQ-028 I-side grants SHALL drive mem_we=0 and mem_wdata=0.
REQ-029 BUSY: mem_req=1; on mem_valid, capture mem_rdata into granted side's rdata (reads only), go to RESP.
REQ-030 Data-side writes SHALL leave d_rdata unchanged.
REQ-031 RESP: granted side's x_valid=1 for exactly one cycle, mem_req=0, then IDLE; no grant in RESP.
REQ-032 Back-to-back: a requester that keeps req high after x_valid gets a new grant no sooner than the IDLE cycle after RESP; minimum period 3 cycles + memory latency.
REQ-033 Wait counter (8 bits) SHALL clear on entry to BUSY and increment each BUSY cycle without mem_valid.
REQ-034 Counter reaching MAX_WAIT without mem_valid: go to RESP, rdata of granted side = 0 (reads), x_valid pulses normally, timeout_err set and held until reset.
REQ-035 mem_valid and counter reaching MAX_WAIT in the same cycle: treat as normal completion, no timeout.
REQ-036 mem_valid in IDLE or RESP SHALL be ignored with no state change.
REQ-037 i_valid and d_valid SHALL never be high in the same cycle.

Reset
REQ-038 Reset SHALL force IDLE, last_grant=D, counter=0, and all outputs to 0 (i_rdata, d_rdata, mem_* included) immediately, independent of clock.
REQ-039 Reset mid-transaction SHALL abandon it with no x_valid pulse; first grant possible in the first IDLE cycle after reset release.

Verification
REQ-040 i_req=1, i_addr=0x100, mem_valid 2 cycles after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, i_rdata=0xDEADBEEF, one i_valid pulse.
REQ-041 i_req and d_req both high from reset release -> I granted first, then D; swap order on next tie.
REQ-042 d_req=1, d_we=1, d_addr=0x200, d_wdata=0x12345678 -> mem_we=1, mem_addr=0x200, mem_wdata=0x12345678; d_valid pulse; d_rdata unchanged.
REQ-043 MAX_WAIT=4, no mem_valid -> RESP after 4 BUSY cycles, i_rdata=0, i_valid pulse, timeout_err=1 until reset.
REQ-044 Reset asserted during BUSY -> all outputs 0 asynchronously, no x_valid, later mem_valid ignored.
REQ-045 mem_valid pulsed while IDLE -> no state change, no valid pulse.
